// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 port arbiter: LC-3b word/line types, arbiter FSM states,
// and the default D-side starvation bound.
package l2_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RELEASE
    } l2_arb_state_t;

    localparam int L2_ARB_MAX_D_STREAK = 4;

endpackage

// File: rtl/l2_arbiter_control.sv
// Grant FSM and D-streak counter for the L2 arbiter; emits one-hot selects
// that steer the routing datapath in the top level.
module l2_arbiter_control
    import l2_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = L2_ARB_MAX_D_STREAK,
    parameter int STREAK_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_read,
    input  logic d_read,
    input  logic d_write,
    input  logic l2_resp,
    output logic sel_i,
    output logic sel_d,
    output logic active
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    l2_arb_state_t         state, state_next;
    logic [STREAK_W-1:0]   streak, streak_next;
    logic                  d_req;

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
        return (v >= STREAK_MAX) ? STREAK_MAX : v + STREAK_W'(1);
    endfunction

    assign d_req = d_read | d_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    always_comb begin
        state_next  = state;
        streak_next = streak;
        unique case (state)
            IDLE: begin
                // Starved I-side wins over a pending D request once the bound is hit.
                if (d_req && i_read && streak == STREAK_MAX) state_next = GRANT_I;
                else if (d_req)                              state_next = GRANT_D;
                else if (i_read)                             state_next = GRANT_I;
            end
            GRANT_I: begin
                if (l2_resp) begin
                    state_next  = RELEASE;
                    streak_next = '0;
                end
            end
            GRANT_D: begin
                if (l2_resp) begin
                    state_next  = RELEASE;
                    streak_next = i_read ? sat_inc(streak) : '0;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sel_i  = (state == GRANT_I);
    assign sel_d  = (state == GRANT_D);
    assign active = sel_i | sel_d;

endmodule

// File: rtl/l2_arbiter.sv
// Shares the unified L2 port between the L1 I-cache and D-cache; the control
// block picks the owner and this level routes address, data and responses.
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = L2_ARB_MAX_D_STREAK,
    parameter int STREAK_W     = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  lc3b_word  i_addr,
    input  logic      i_read,
    output lc3b_block i_rdata,
    output logic      i_resp,
    input  lc3b_word  d_addr,
    input  logic      d_read,
    input  logic      d_write,
    input  lc3b_block d_wdata,
    output lc3b_block d_rdata,
    output logic      d_resp,
    output lc3b_word  l2_addr,
    output logic      l2_read,
    output logic      l2_write,
    output lc3b_block l2_wdata,
    input  lc3b_block l2_rdata,
    input  logic      l2_resp
);

    logic sel_i, sel_d, active;

    l2_arbiter_control #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .STREAK_W     (STREAK_W)
    ) u_control (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_read  (i_read),
        .d_read  (d_read),
        .d_write (d_write),
        .l2_resp (l2_resp),
        .sel_i   (sel_i),
        .sel_d   (sel_d),
        .active  (active)
    );

    // Everything is zero outside a grant so idle buses never leak stale data.
    always_comb begin
        l2_addr  = '0;
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_wdata = '0;
        i_resp   = 1'b0;
        i_rdata  = '0;
        d_resp   = 1'b0;
        d_rdata  = '0;
        if (active) begin
            if (sel_d) begin
                l2_addr  = d_addr;
                l2_read  = d_read & ~d_write;
                l2_write = d_write;
                l2_wdata = d_wdata;
                if (l2_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = l2_rdata;
                end
            end else begin
                l2_addr = i_addr;
                l2_read = 1'b1;
                if (l2_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = l2_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized traffic,
// compared each cycle against a transaction-level model of the arbitration rules.
module tb_l2_arbiter;

    localparam int MAX = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  i_addr, d_addr, l2_addr;
    logic         i_read, d_read, d_write;
    logic [127:0] i_rdata, d_rdata, d_wdata, l2_wdata, l2_rdata;
    logic         i_resp, d_resp, l2_read, l2_write, l2_resp;

    int checks = 0;
    int errors = 0;

    // Model: who owns the port, whether we are in the post-transaction gap,
    // and how many D transactions have completed in a row while I waited.
    bit m_busy, m_who_d, m_gap;
    int m_run, m_lat;

    bit i_done, d_done, use_fix, force_resp;
    int i_rate, d_rate, fixed_lat;
    int n_i, n_d;
    logic [127:0] rdata_fix;

    l2_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_addr   (i_addr),
        .i_read   (i_read),
        .i_rdata  (i_rdata),
        .i_resp   (i_resp),
        .d_addr   (d_addr),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .l2_addr  (l2_addr),
        .l2_read  (l2_read),
        .l2_write (l2_write),
        .l2_wdata (l2_wdata),
        .l2_rdata (l2_rdata),
        .l2_resp  (l2_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        bit           dreq;
        logic         e_rd, e_wr, e_iv, e_dv;
        logic [127:0] e_addr, e_wd;
        dreq   = d_read | d_write;
        e_rd   = m_busy && (m_who_d ? (d_read && !d_write) : 1'b1);
        e_wr   = m_busy && m_who_d && d_write;
        e_addr = !m_busy ? 128'd0 : (m_who_d ? {112'd0, d_addr} : {112'd0, i_addr});
        e_wd   = (m_busy && m_who_d) ? d_wdata : 128'd0;
        e_iv   = m_busy && !m_who_d && l2_resp;
        e_dv   = m_busy && m_who_d && l2_resp;
        check("l2_read",  l2_read,  e_rd);
        check("l2_write", l2_write, e_wr);
        check("l2_addr",  l2_addr,  e_addr);
        check("l2_wdata", l2_wdata, e_wd);
        check("i_resp",   i_resp,   e_iv);
        check("i_rdata",  i_rdata,  e_iv ? l2_rdata : 128'd0);
        check("d_resp",   d_resp,   e_dv);
        check("d_rdata",  d_rdata,  e_dv ? l2_rdata : 128'd0);
        if (i_resp) n_i++;
        if (d_resp) n_d++;
        i_done = e_iv;
        d_done = e_dv;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_busy) begin
            if (l2_resp) begin
                m_busy = 1'b0;
                m_gap  = 1'b1;
                if (m_who_d) m_run = i_read ? ((m_run + 1 > MAX) ? MAX : m_run + 1) : 0;
                else         m_run = 0;
            end
        end else if (dreq || i_read) begin
            m_busy  = 1'b1;
            m_who_d = dreq && !(i_read && m_run >= MAX);
            m_lat   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3));
        end
    endtask

    // Called just after a falling edge: requesters and L2 react, then outputs are checked.
    task automatic drive_and_step();
        int k;
        if (i_done) begin
            i_read = 1'b0;
            i_done = 1'b0;
        end else if (!i_read && i_rate != 0 && $urandom_range(i_rate - 1) == 0) begin
            i_read = 1'b1;
            i_addr = 16'($urandom);
        end
        if (d_done) begin
            d_read  = 1'b0;
            d_write = 1'b0;
            d_done  = 1'b0;
        end else if (!(d_read || d_write) && d_rate != 0 && $urandom_range(d_rate - 1) == 0) begin
            k       = int'($urandom_range(2));
            d_read  = (k != 1);
            d_write = (k != 0);
            d_addr  = 16'($urandom);
            d_wdata = rnd128();
        end
        l2_rdata = use_fix ? rdata_fix : rnd128();
        if (m_busy) begin
            l2_resp = (m_lat == 0);
            if (m_lat > 0) m_lat--;
        end else begin
            l2_resp = force_resp || ($urandom_range(7) == 0);
        end
        #1;
        step();
    endtask

    task automatic tick();
        @(negedge clk);
        drive_and_step();
    endtask

    task automatic settle(input int budget);
        int n = 0;
        while ((i_read || d_read || d_write || m_busy || m_gap) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("settle_timeout", 1'b0, 1'b1);
        tick();
    endtask

    initial begin
        int n0_i, n0_d, n;
        rst_n = 1'b0;
        i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
        m_busy = 0; m_who_d = 0; m_gap = 0; m_run = 0; m_lat = 0;
        i_done = 0; d_done = 0; use_fix = 0; force_resp = 0;
        i_rate = 0; d_rate = 0; fixed_lat = -1; n_i = 0; n_d = 0;
        rdata_fix = '0;

        repeat (2) @(negedge clk);
        check("rst_l2_read",  l2_read,  1'b0);
        check("rst_l2_write", l2_write, 1'b0);
        check("rst_l2_addr",  l2_addr,  16'd0);
        check("rst_resp",     {i_resp, d_resp}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Single I read with a fixed line pattern and three-cycle L2 latency.
        use_fix = 1; rdata_fix = {16{8'hA5}}; fixed_lat = 2;
        n0_i = n_i; n0_d = n_d;
        @(negedge clk);
        i_read = 1'b1; i_addr = 16'h1200;
        drive_and_step();
        settle(30);
        check("single_i_count", n_i - n0_i, 1);
        check("single_i_no_d",  n_d - n0_d, 0);
        use_fix = 0;

        // D write-back.
        n0_d = n_d;
        @(negedge clk);
        d_write = 1'b1; d_addr = 16'h3400; d_wdata = {4{32'hDEADBEEF}};
        drive_and_step();
        settle(30);
        check("d_wb_count", n_d - n0_d, 1);

        // Simultaneous I and D from IDLE: D served first.
        n0_i = n_i; n0_d = n_d; fixed_lat = 1;
        @(negedge clk);
        i_read = 1'b1; i_addr = 16'h0040; d_read = 1'b1; d_addr = 16'h0080;
        drive_and_step();
        n = 0;
        while (n_i == n0_i && n < 40) begin tick(); n++; end
        check("simul_d_first", n_d - n0_d, 1);
        settle(30);

        // Starvation bound: I held, D re-requests after every release.
        n0_i = n_i; n0_d = n_d; fixed_lat = 0; d_rate = 1;
        @(negedge clk);
        i_read = 1'b1; i_addr = 16'h0A00; d_write = 1'b1; d_addr = 16'h0B00; d_wdata = rnd128();
        drive_and_step();
        n = 0;
        while (n_i == n0_i && n < 100) begin tick(); n++; end
        check("starve_d_grants", n_d - n0_d, MAX);
        n0_d = n_d; n = 0;
        while (n_d == n0_d && n < 20) begin tick(); n++; end
        check("starve_d_resumes", n_d - n0_d, 1);
        d_rate = 0;
        settle(40);

        // Read and write together: write wins.
        n0_d = n_d; fixed_lat = 1;
        @(negedge clk);
        d_read = 1'b1; d_write = 1'b1; d_addr = 16'h5555; d_wdata = rnd128();
        drive_and_step();
        tick();
        check("rw_both_write", l2_write, 1'b1);
        check("rw_both_read",  l2_read,  1'b0);
        settle(30);
        check("rw_both_count", n_d - n0_d, 1);

        // Reset abort while D waits on L2.
        fixed_lat = 20;
        @(negedge clk);
        d_write = 1'b1; d_addr = 16'h3400; d_wdata = rnd128();
        drive_and_step();
        tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_l2_write", l2_write, 1'b0);
        check("abort_l2_addr",  l2_addr,  16'd0);
        m_busy = 0; m_gap = 0; m_run = 0; d_write = 1'b0; d_done = 1'b0; l2_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n0_d = n_d; force_resp = 1;
        tick();
        force_resp = 0;
        check("abort_no_d_resp", n_d - n0_d, 0);
        fixed_lat = -1;

        // Randomized traffic.
        i_rate = 3; d_rate = 2;
        repeat (3000) tick();
        i_rate = 0; d_rate = 0;
        settle(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
